// File: rtl/data_checker_if.sv
// Read-back beat channel: valid/ready handshake carrying one WIDTH-bit beat.
// The checker sits on the slave side and consumes a beat when read_valid && read_ready.
interface data_checker_if #(
    parameter int WIDTH = 256
) ();
    logic             read_valid;
    logic             read_ready;
    logic [WIDTH-1:0] read_data;

    modport master (output read_valid, output read_data, input read_ready);
    modport slave  (input read_valid, input read_data, output read_ready);
endinterface

// File: rtl/data_checker.sv
// Compares read-back beats against a locally generated LFSR/rotate pattern; results retire one cycle after acceptance.
// Backpressure: read_ready drops outside CHECK, on start, and while a mismatch waits to halt the checker.
module data_checker #(
    parameter int                    WIDTH       = 256,
    parameter int                    LFSR_WIDTH  = 32,
    parameter logic [LFSR_WIDTH-2:0] LFSR_TAPS   = 31'b0100011000000000000000000000000,
    parameter int                    COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   stop_on_error,
    input  logic                   mode_selector,
    input  logic [WIDTH-1:0]       initial_value,
    input  logic                   shift_enable,
    input  logic                   shift_direction,
    input  logic [WIDTH/8-1:0]     final_byte_mask,
    data_checker_if.slave          rd,
    output logic                   busy,
    output logic                   halted,
    output logic                   error_flag,
    output logic [COUNT_WIDTH-1:0] checked_count,
    output logic [COUNT_WIDTH-1:0] error_count,
    output logic [COUNT_WIDTH-1:0] first_error_index,
    output logic [WIDTH/8-1:0]     first_error_byte_mask
);
    localparam int NBYTES = WIDTH / 8;
    localparam int NSEG   = WIDTH / LFSR_WIDTH;

    typedef enum logic [1:0] {IDLE, CHECK, HALTED} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  expected;
    logic              s1_vld;
    logic [NBYTES-1:0] s1_mis;
    logic [NBYTES-1:0] byte_mis;
    logic              s1_err;
    logic              accept;

    // Each LFSR segment is an independent Galois-style shifter.
    function automatic logic [WIDTH-1:0] next_expected(input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0]      res;
        logic [LFSR_WIDTH-1:0] s;
        res = cur;
        if (mode_selector) begin
            for (int g = 0; g < NSEG; g++) begin
                s = cur[g*LFSR_WIDTH +: LFSR_WIDTH];
                res[g*LFSR_WIDTH +: LFSR_WIDTH] =
                    {s[0], ({(LFSR_WIDTH-1){s[0]}} & LFSR_TAPS) ^ s[LFSR_WIDTH-1:1]};
            end
        end else if (shift_enable) begin
            res = shift_direction ? {cur[0], cur[WIDTH-1:1]} : {cur[WIDTH-2:0], cur[WIDTH-1]};
        end
        return res;
    endfunction

    always_comb begin
        byte_mis = '0;
        for (int i = 0; i < NBYTES; i++) begin
            byte_mis[i] = final_byte_mask[i] && (rd.read_data[8*i +: 8] != expected[8*i +: 8]);
        end
    end

    assign s1_err        = s1_vld && (|s1_mis);
    assign rd.read_ready = (state == CHECK) && enable && !start && !(stop_on_error && s1_err);
    assign accept        = rd.read_valid && rd.read_ready;
    assign busy          = (state == CHECK);
    assign halted        = (state == HALTED);

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = CHECK;
        end else if (stop && state != IDLE) begin
            state_nxt = IDLE;
        end else if (state == CHECK && stop_on_error && s1_err) begin
            state_nxt = HALTED;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            expected              <= '0;
            s1_vld                <= 1'b0;
            s1_mis                <= '0;
            error_flag            <= 1'b0;
            checked_count         <= '0;
            error_count           <= '0;
            first_error_index     <= '0;
            first_error_byte_mask <= '0;
        end else if (start) begin
            expected              <= initial_value;
            s1_vld                <= 1'b0;
            s1_mis                <= '0;
            error_flag            <= 1'b0;
            checked_count         <= '0;
            error_count           <= '0;
            first_error_index     <= '0;
            first_error_byte_mask <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_mis   <= byte_mis;
                expected <= next_expected(expected);
            end
            // Stage 2 retires even after stop so the last accepted beat is counted.
            if (s1_vld) begin
                if (checked_count != '1) begin
                    checked_count <= checked_count + 1'b1;
                end
                if (|s1_mis) begin
                    error_flag <= 1'b1;
                    if (error_count != '1) begin
                        error_count <= error_count + 1'b1;
                    end
                    if (!error_flag) begin
                        first_error_index     <= checked_count;
                        first_error_byte_mask <= s1_mis;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_data_checker.sv
// Self-checking bench for data_checker: scoreboard of expected per-beat byte mismatches
// retired against the DUT counters, plus scenario tasks for control and boundary cases.
module tb_data_checker;
    localparam int W  = 256;
    localparam int NB = W / 8;
    localparam int CW = 4;
    localparam logic [30:0] TAPS = 31'b0100011000000000000000000000000;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          stop_on_error = 1'b0;
    logic          mode_selector = 1'b0;
    logic [W-1:0]  initial_value = '0;
    logic          shift_enable = 1'b0;
    logic          shift_direction = 1'b0;
    logic [NB-1:0] final_byte_mask = '1;
    logic          busy, halted, error_flag;
    logic [CW-1:0] checked_count, error_count, first_error_index;
    logic [NB-1:0] first_error_byte_mask;

    data_checker_if #(.WIDTH(W)) rd_if ();

    data_checker #(.WIDTH(W), .LFSR_WIDTH(32), .LFSR_TAPS(TAPS), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .start(start), .stop(stop),
        .stop_on_error(stop_on_error), .mode_selector(mode_selector),
        .initial_value(initial_value), .shift_enable(shift_enable),
        .shift_direction(shift_direction), .final_byte_mask(final_byte_mask), .rd(rd_if),
        .busy(busy), .halted(halted), .error_flag(error_flag),
        .checked_count(checked_count), .error_count(error_count),
        .first_error_index(first_error_index), .first_error_byte_mask(first_error_byte_mask)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            failures = 0;
    logic [NB-1:0] sb_q[$];
    logic [NB-1:0] mon_e;
    logic [W-1:0]  mdl_exp = '0;
    int            mon_cnt = 0;
    int            mon_err = 0;
    bit            mon_first = 1'b1;
    bit            mon_en = 1'b0;

    // Scoreboard retirement: every counter step pops one expected byte-mismatch vector.
    always @(negedge clock) begin
        if (mon_en && resetn && checked_count !== mon_cnt[CW-1:0]) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_beat: checked_count=%0d, expected %0d", checked_count, mon_cnt);
                mon_cnt = int'(checked_count);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e != '0 && mon_first) begin
                    checks++;
                    if (first_error_index !== mon_cnt[CW-1:0] || first_error_byte_mask !== mon_e) begin
                        failures++;
                        $display("FAIL sb_first_error: index=%0d mask=%h, expected index=%0d mask=%h",
                                 first_error_index, first_error_byte_mask, mon_cnt, mon_e);
                    end
                    mon_first = 1'b0;
                end
                mon_cnt++;
                if (mon_e != '0) mon_err++;
                if (checked_count !== mon_cnt[CW-1:0] || error_count !== mon_err[CW-1:0]) begin
                    failures++;
                    $display("FAIL sb_counts: checked=%0d errors=%0d, expected checked=%0d errors=%0d",
                             checked_count, error_count, mon_cnt, mon_err);
                end
            end
        end
    end

    function automatic logic [W-1:0] mdl_step(input logic [W-1:0] c);
        logic [W-1:0]  r;
        logic [31:0]   s;
        r = c;
        if (mode_selector) begin
            for (int g = 0; g < W/32; g++) begin
                s = c[g*32 +: 32];
                r[g*32 +: 32] = {s[0], ({31{s[0]}} & TAPS) ^ s[31:1]};
            end
        end else if (shift_enable) begin
            r = shift_direction ? {c[0], c[W-1:1]} : {c[W-2:0], c[W-1]};
        end
        return r;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] init);
        @(negedge clock);
        initial_value = init;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        mdl_exp = init;
        sb_q.delete();
        mon_cnt = 0;
        mon_err = 0;
        mon_first = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic send_beat(input logic [W-1:0] d);
        bit            ok;
        logic [NB-1:0] m;
        ok = 1'b0;
        rd_if.read_data = d;
        rd_if.read_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (rd_if.read_ready === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL beat_accept: read_ready stayed 0 for 20 cycles, required 1");
        end else begin
            m = '0;
            for (int b = 0; b < NB; b++) m[b] = final_byte_mask[b] && (d[8*b +: 8] != mdl_exp[8*b +: 8]);
            sb_q.push_back(m);
            mdl_exp = mdl_step(mdl_exp);
        end
        @(posedge clock);
        #1;
        rd_if.read_valid = 1'b0;
    endtask

    task automatic test_reset;
        enable = 1'b1;
        rd_if.read_valid = 1'b1;
        rd_if.read_data = '0;
        #12;
        checks++;
        if ({busy, halted, error_flag, checked_count, error_count, first_error_index, first_error_byte_mask, rd_if.read_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b halted=%b flag=%b chk=%0d err=%0d, required all 0",
                     busy, halted, error_flag, checked_count, error_count);
        end
        @(negedge clock);
        resetn = 1'b1;
        settle(3);
        checks++;
        if (rd_if.read_ready !== 1'b0 || checked_count !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_needs_start: ready=%b chk=%0d busy=%b, required 0/0/0",
                     rd_if.read_ready, checked_count, busy);
        end
        rd_if.read_valid = 1'b0;
    endtask

    task automatic test_rotate;
        logic [W-1:0] v;
        mode_selector = 1'b0;
        shift_enable = 1'b1;
        shift_direction = 1'b0;
        final_byte_mask = '1;
        do_start(256'd1);
        v = 256'd1; send_beat(v);
        v = 256'd2; send_beat(v);
        v = 256'd4; send_beat(v);
        settle(2);
        checks++;
        if (checked_count !== 4'd3 || error_count !== 4'd0 || error_flag !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rotate_left: chk=%0d err=%0d flag=%b busy=%b, required 3/0/0/1",
                     checked_count, error_count, error_flag, busy);
        end
        shift_direction = 1'b1;
        do_start(256'd1);
        v = 256'd1; send_beat(v);
        v = '0; v[W-1] = 1'b1; send_beat(v);
        v = '0; v[W-2] = 1'b1; send_beat(v);
        settle(2);
        checks++;
        if (checked_count !== 4'd3 || error_count !== 4'd0 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL rotate_right: chk=%0d err=%0d pending=%0d, required 3/0/0",
                     checked_count, error_count, sb_q.size());
        end
    endtask

    task automatic test_lfsr;
        logic [W-1:0] v;
        mode_selector = 1'b1;
        do_start(256'd1);
        v = 256'd1; send_beat(v);
        v = '0; v[31:0] = 32'hA300_0000; send_beat(v);
        settle(2);
        checks++;
        if (checked_count !== 4'd2 || error_count !== 4'd0 || error_flag !== 1'b0) begin
            failures++;
            $display("FAIL lfsr_seed1: chk=%0d err=%0d flag=%b, required 2/0/0",
                     checked_count, error_count, error_flag);
        end
    endtask

    task automatic test_corrupt;
        logic [W-1:0] init, flip;
        mode_selector = 1'b0;
        shift_enable = 1'b0;
        init = {8{32'hC0FF_EE11}};
        flip = '0;
        flip[47:40] = 8'h5A;
        do_start(init);
        send_beat(init);
        send_beat(init);
        send_beat(init ^ flip);
        send_beat(init);
        settle(2);
        checks++;
        if (checked_count !== 4'd4 || error_count !== 4'd1 || error_flag !== 1'b1) begin
            failures++;
            $display("FAIL corrupt_counts: chk=%0d err=%0d flag=%b, required 4/1/1",
                     checked_count, error_count, error_flag);
        end
        checks++;
        if (first_error_index !== 4'd2 || first_error_byte_mask !== 32'h0000_0020) begin
            failures++;
            $display("FAIL corrupt_first: index=%0d mask=%h, required 2/00000020",
                     first_error_index, first_error_byte_mask);
        end
    endtask

    task automatic test_masked;
        logic [W-1:0] init, flip, v;
        init = {8{32'hC0FF_EE11}};
        flip = '0;
        flip[47:40] = 8'h5A;
        final_byte_mask = '1;
        final_byte_mask[5] = 1'b0;
        do_start(init);
        send_beat(init);
        send_beat(init);
        send_beat(init ^ flip);
        send_beat(init);
        settle(2);
        checks++;
        if (checked_count !== 4'd4 || error_count !== 4'd0 || error_flag !== 1'b0) begin
            failures++;
            $display("FAIL masked_byte5: chk=%0d err=%0d flag=%b, required 4/0/0",
                     checked_count, error_count, error_flag);
        end
        final_byte_mask = '0;
        do_start(init);
        for (int i = 0; i < 3; i++) begin
            v = {8{$urandom()}};
            send_beat(v);
        end
        settle(2);
        checks++;
        if (checked_count !== 4'd3 || error_count !== 4'd0 || error_flag !== 1'b0) begin
            failures++;
            $display("FAIL mask_zero: chk=%0d err=%0d flag=%b, required 3/0/0",
                     checked_count, error_count, error_flag);
        end
        final_byte_mask = '1;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] seed, v;
        mode_selector = 1'b1;
        for (int g = 0; g < W/32; g++) seed[g*32 +: 32] = $urandom() | 32'h1;
        do_start(seed);
        for (int i = 0; i < 8; i++) send_beat(mdl_exp);
        v = mdl_exp;
        v[247:240] = ~v[247:240];
        send_beat(v);
        settle(2);
        checks++;
        if (checked_count !== 4'd9 || error_count !== 4'd1 || first_error_index !== 4'd8 ||
            first_error_byte_mask !== 32'h4000_0000 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL back_to_back: chk=%0d err=%0d idx=%0d mask=%h, required 9/1/8/40000000",
                     checked_count, error_count, first_error_index, first_error_byte_mask);
        end
    endtask

    task automatic test_stop;
        mode_selector = 1'b0;
        shift_enable = 1'b1;
        shift_direction = 1'b0;
        do_start(256'h3);
        send_beat(mdl_exp);
        send_beat(mdl_exp);
        stop = 1'b1;
        @(posedge clock);
        #1;
        stop = 1'b0;
        rd_if.read_data = mdl_exp;
        rd_if.read_valid = 1'b1;
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || checked_count !== 4'd2) begin
            failures++;
            $display("FAIL stop_idle: busy=%b halted=%b chk=%0d, required 0/0/2", busy, halted, checked_count);
        end
        settle(3);
        checks++;
        if (rd_if.read_ready !== 1'b0 || checked_count !== 4'd2 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL stop_ignores_beats: ready=%b chk=%0d, required 0/2", rd_if.read_ready, checked_count);
        end
        rd_if.read_valid = 1'b0;
    endtask

    task automatic test_stop_on_error;
        logic [W-1:0] init;
        mode_selector = 1'b0;
        shift_enable = 1'b0;
        stop_on_error = 1'b1;
        init = {8{32'h1234_5678}};
        do_start(init);
        send_beat(~init);
        rd_if.read_data = init;
        rd_if.read_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (rd_if.read_ready !== 1'b0) begin
            failures++;
            $display("FAIL soe_ready_drop: read_ready=%b, required 0", rd_if.read_ready);
        end
        @(posedge clock);
        #1;
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || checked_count !== 4'd1 || error_count !== 4'd1) begin
            failures++;
            $display("FAIL soe_halt: halted=%b busy=%b chk=%0d err=%0d, required 1/0/1/1",
                     halted, busy, checked_count, error_count);
        end
        settle(2);
        checks++;
        if (checked_count !== 4'd1 || rd_if.read_ready !== 1'b0 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL soe_no_accept: chk=%0d ready=%b, required 1/0", checked_count, rd_if.read_ready);
        end
        rd_if.read_valid = 1'b0;
        do_start(init);
        checks++;
        if (busy !== 1'b1 || halted !== 1'b0 || {error_flag, checked_count, error_count,
            first_error_index, first_error_byte_mask} !== '0) begin
            failures++;
            $display("FAIL soe_restart: busy=%b halted=%b flag=%b chk=%0d err=%0d, required 1/0/0/0/0",
                     busy, halted, error_flag, checked_count, error_count);
        end
        stop_on_error = 1'b0;
    endtask

    task automatic test_saturate;
        logic [W-1:0] init;
        mode_selector = 1'b0;
        shift_enable = 1'b0;
        init = {8{32'h0F0F_A5A5}};
        do_start(init);
        mon_en = 1'b0;
        for (int i = 0; i < 18; i++) send_beat(~init);
        settle(2);
        checks++;
        if (checked_count !== 4'hF || error_count !== 4'hF || error_flag !== 1'b1 || first_error_index !== 4'd0) begin
            failures++;
            $display("FAIL saturate: chk=%0d err=%0d flag=%b idx=%0d, required 15/15/1/0",
                     checked_count, error_count, error_flag, first_error_index);
        end
    endtask

    task automatic test_async_reset;
        logic [W-1:0] init;
        mode_selector = 1'b1;
        init = {8{32'h0000_0001}};
        do_start(init);
        for (int i = 0; i < 5; i++) send_beat(mdl_exp);
        settle(2);
        checks++;
        if (checked_count !== 4'd5 || error_count !== 4'd0) begin
            failures++;
            $display("FAIL pre_reset_count: chk=%0d err=%0d, required 5/0", checked_count, error_count);
        end
        mon_en = 1'b0;
        @(negedge clock);
        #2;
        resetn = 1'b0;
        rd_if.read_valid = 1'b1;
        #1;
        checks++;
        if ({busy, halted, error_flag, checked_count, error_count, first_error_index, first_error_byte_mask, rd_if.read_ready} !== '0) begin
            failures++;
            $display("FAIL async_reset: busy=%b chk=%0d err=%0d ready=%b, required all 0",
                     busy, checked_count, error_count, rd_if.read_ready);
        end
        @(negedge clock);
        resetn = 1'b1;
        settle(3);
        checks++;
        if (rd_if.read_ready !== 1'b0 || checked_count !== 4'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ignore_beats: ready=%b chk=%0d busy=%b, required 0/0/0",
                     rd_if.read_ready, checked_count, busy);
        end
        rd_if.read_valid = 1'b0;
        do_start(init);
        send_beat(mdl_exp);
        settle(2);
        checks++;
        if (checked_count !== 4'd1 || error_count !== 4'd0 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL post_reset_restart: chk=%0d err=%0d, required 1/0", checked_count, error_count);
        end
    endtask

    initial begin
        rd_if.read_valid = 1'b0;
        rd_if.read_data = '0;
        test_reset();
        test_rotate();
        test_lfsr();
        test_corrupt();
        test_masked();
        test_back_to_back();
        test_stop();
        test_stop_on_error();
        test_saturate();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
